// File: rtl/risc_core_ws.sv
// Parametrised accumulator core running the eight-opcode ISA over a split valid/ready memory port.
// Request fields are registered from the next state, so the memory port never glitches.
module risc_core_ws #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 13
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  input  logic              resume,
  output logic              halted,
  output logic              retire,
  output logic [DATA_W-1:0] acc_out,
  output logic [ADDR_W-1:0] pc_out,
  output logic              zero
);

  typedef enum logic [2:0] {
    StBoot, StFetchHi, StFetchLo, StExec, StMemRd, StMemWr, StHalt
  } state_e;

  localparam logic [2:0] OpHlt = 3'd0;
  localparam logic [2:0] OpSkz = 3'd1;
  localparam logic [2:0] OpAdd = 3'd2;
  localparam logic [2:0] OpAnd = 3'd3;
  localparam logic [2:0] OpXor = 3'd4;
  localparam logic [2:0] OpSto = 3'd6;
  localparam logic [2:0] OpJmp = 3'd7;

  state_e            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_pc, w_pc_nxt;
  logic [DATA_W-1:0] r_acc, w_acc_nxt;
  logic [DATA_W-1:0] r_ir_hi, w_ir_hi_nxt;
  logic [DATA_W-1:0] r_ir_lo, w_ir_lo_nxt;
  logic              r_mem_req, w_mem_req_nxt;
  logic              r_mem_we, w_mem_we_nxt;
  logic [ADDR_W-1:0] r_mem_addr, w_mem_addr_nxt;
  logic [DATA_W-1:0] r_mem_wdata, w_mem_wdata_nxt;
  logic              w_done;
  logic              w_zero;
  logic              w_retire;
  logic [2:0]        w_opcode;
  logic [ADDR_W-1:0] w_operand;
  logic              w_unused_hi;

  assign w_opcode    = r_ir_hi[DATA_W-1 -: 3];
  assign w_operand   = {r_ir_hi[ADDR_W-DATA_W-1:0], r_ir_lo};
  // Bits between the operand field and the opcode carry no meaning.
  assign w_unused_hi = ^r_ir_hi;
  assign w_done      = r_mem_req & mem_ready;
  assign w_zero      = (r_acc == '0);

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_acc_nxt   = r_acc;
    w_ir_hi_nxt = r_ir_hi;
    w_ir_lo_nxt = r_ir_lo;
    w_retire    = 1'b0;
    unique case (r_state)
      StBoot: w_state_nxt = StFetchHi;
      StFetchHi: begin
        if (w_done) begin
          w_ir_hi_nxt = mem_rdata;
          w_pc_nxt    = r_pc + ADDR_W'(1);
          w_state_nxt = StFetchLo;
        end
      end
      StFetchLo: begin
        if (w_done) begin
          w_ir_lo_nxt = mem_rdata;
          w_pc_nxt    = r_pc + ADDR_W'(1);
          w_state_nxt = StExec;
        end
      end
      StExec: begin
        case (w_opcode)
          OpHlt: begin
            w_state_nxt = StHalt;
            w_retire    = 1'b1;
          end
          OpSkz: begin
            if (w_zero) w_pc_nxt = r_pc + ADDR_W'(2);
            w_state_nxt = StFetchHi;
            w_retire    = 1'b1;
          end
          OpJmp: begin
            w_pc_nxt    = w_operand;
            w_state_nxt = StFetchHi;
            w_retire    = 1'b1;
          end
          OpSto:   w_state_nxt = StMemWr;
          default: w_state_nxt = StMemRd;
        endcase
      end
      StMemRd: begin
        if (w_done) begin
          case (w_opcode)
            OpAdd:   w_acc_nxt = r_acc + mem_rdata;
            OpAnd:   w_acc_nxt = r_acc & mem_rdata;
            OpXor:   w_acc_nxt = r_acc ^ mem_rdata;
            default: w_acc_nxt = mem_rdata;
          endcase
          w_state_nxt = StFetchHi;
          w_retire    = 1'b1;
        end
      end
      StMemWr: begin
        if (w_done) begin
          w_state_nxt = StFetchHi;
          w_retire    = 1'b1;
        end
      end
      StHalt: begin
        if (resume) w_state_nxt = StFetchHi;
      end
      default: w_state_nxt = StBoot;
    endcase
  end

  // Request fields for the state being entered; held unchanged while a transaction waits.
  always_comb begin
    w_mem_req_nxt   = 1'b0;
    w_mem_we_nxt    = 1'b0;
    w_mem_addr_nxt  = r_mem_addr;
    w_mem_wdata_nxt = r_mem_wdata;
    unique case (w_state_nxt)
      StFetchHi, StFetchLo: begin
        w_mem_req_nxt  = 1'b1;
        w_mem_addr_nxt = w_pc_nxt;
      end
      StMemRd: begin
        w_mem_req_nxt  = 1'b1;
        w_mem_addr_nxt = w_operand;
      end
      StMemWr: begin
        w_mem_req_nxt   = 1'b1;
        w_mem_we_nxt    = 1'b1;
        w_mem_addr_nxt  = w_operand;
        w_mem_wdata_nxt = r_acc;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= StBoot;
      r_pc        <= '0;
      r_acc       <= '0;
      r_ir_hi     <= '0;
      r_ir_lo     <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_pc        <= w_pc_nxt;
      r_acc       <= w_acc_nxt;
      r_ir_hi     <= w_ir_hi_nxt;
      r_ir_lo     <= w_ir_lo_nxt;
      r_mem_req   <= w_mem_req_nxt;
      r_mem_we    <= w_mem_we_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_wdata <= w_mem_wdata_nxt;
    end
  end

  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign halted    = (r_state == StHalt);
  assign retire    = w_retire;
  assign acc_out   = r_acc;
  assign pc_out    = r_pc;
  assign zero      = w_zero;

endmodule

// File: tb/tb_risc_core_ws.sv
// Directed bench for risc_core_ws: an 8/13 core on a wait-state memory model plus a 16/20 core.
module tb_risc_core_ws;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, mem_req, mem_we, mem_ready, resume, halted, retire, zero;
  logic [12:0] mem_addr, pc_out;
  logic [7:0]  mem_wdata, mem_rdata, acc_out;

  logic        rst16, req16, we16, ready16, resume16, halted16, retire16, zero16;
  logic [19:0] addr16, pc16;
  logic [15:0] wdata16, rdata16, acc16;

  int n_cmp = 0;
  int n_bad = 0;

  risc_core_ws #(.DATA_W(8), .ADDR_W(13)) u_dut (
    .clk(clk), .rst(rst), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .resume(resume),
    .halted(halted), .retire(retire), .acc_out(acc_out), .pc_out(pc_out), .zero(zero)
  );

  risc_core_ws #(.DATA_W(16), .ADDR_W(20)) u_dut16 (
    .clk(clk), .rst(rst16), .mem_req(req16), .mem_we(we16), .mem_addr(addr16),
    .mem_wdata(wdata16), .mem_rdata(rdata16), .mem_ready(ready16), .resume(resume16),
    .halted(halted16), .retire(retire16), .acc_out(acc16), .pc_out(pc16), .zero(zero16)
  );

  // Memory model: combinational read, ready after wait_cfg low cycles, writes logged only.
  logic [7:0]  mem [0:8191];
  logic [15:0] mem16 [0:1048575];
  int          wait_cfg = 0;
  int          wait_cnt = 0;
  int          wr_count = 0;
  logic [12:0] last_wr_addr = '0;
  logic [7:0]  last_wr_data = '0;

  assign mem_rdata = mem[mem_addr];
  assign mem_ready = (wait_cnt >= wait_cfg);
  assign rdata16   = mem16[addr16];
  assign ready16   = 1'b1;

  always @(posedge clk) begin
    if (!rst && mem_req) begin
      if (mem_ready) begin
        wait_cnt <= 0;
        if (mem_we) begin
          wr_count     <= wr_count + 1;
          last_wr_addr <= mem_addr;
          last_wr_data <= mem_wdata;
        end
      end else begin
        wait_cnt <= wait_cnt + 1;
      end
    end else begin
      wait_cnt <= 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 8192; i++) mem[i] = 8'h00;
  endtask

  task automatic boot(input int wc);
    rst      = 1'b1;
    wait_cfg = wc;
    tick();
    rst = 1'b0;
  endtask

  task automatic run_to_halt(input string name, input int budget);
    int c;
    c = 0;
    while (!halted && c < budget) begin
      tick();
      c++;
    end
    n_cmp++;
    if (halted !== 1'b1) begin n_bad++; $display("FAIL %s_timeout: halted=%b want 1", name, halted); end
  endtask

  task automatic test_reset();
    clear_mem();
    rst = 1'b1;
    tick();
    tick();
    n_cmp++; if (mem_req !== 1'b0) begin n_bad++; $display("FAIL rst_req: got %b want 0", mem_req); end
    n_cmp++; if (mem_we !== 1'b0) begin n_bad++; $display("FAIL rst_we: got %b want 0", mem_we); end
    n_cmp++; if (mem_addr !== 13'h0) begin n_bad++; $display("FAIL rst_addr: got %h want 0", mem_addr); end
    n_cmp++; if (mem_wdata !== 8'h0) begin n_bad++; $display("FAIL rst_wdata: got %h want 0", mem_wdata); end
    n_cmp++; if (halted !== 1'b0) begin n_bad++; $display("FAIL rst_halted: got %b want 0", halted); end
    n_cmp++; if (retire !== 1'b0) begin n_bad++; $display("FAIL rst_retire: got %b want 0", retire); end
    n_cmp++; if (acc_out !== 8'h0) begin n_bad++; $display("FAIL rst_acc: got %h want 0", acc_out); end
    n_cmp++; if (pc_out !== 13'h0) begin n_bad++; $display("FAIL rst_pc: got %h want 0", pc_out); end
    n_cmp++; if (zero !== 1'b1) begin n_bad++; $display("FAIL rst_zero: got %b want 1", zero); end
    rst = 1'b0;
    n_cmp++; if (mem_req !== 1'b0) begin n_bad++; $display("FAIL boot_req: got %b want 0", mem_req); end
    tick();
    n_cmp++; if (mem_req !== 1'b1) begin n_bad++; $display("FAIL boot_req1: got %b want 1", mem_req); end
    n_cmp++; if (mem_addr !== 13'h0) begin n_bad++; $display("FAIL boot_addr: got %h want 0", mem_addr); end
    n_cmp++; if (mem_we !== 1'b0) begin n_bad++; $display("FAIL boot_we: got %b want 0", mem_we); end
  endtask

  task automatic test_lda_add();
    int cyc, rets;
    clear_mem();
    mem[0] = 8'hA1; mem[1] = 8'h00;  // LDA 0x100
    mem[2] = 8'h41; mem[3] = 8'h01;  // ADD 0x101
    mem[4] = 8'h00; mem[5] = 8'h00;  // HLT
    mem[13'h100] = 8'hF0; mem[13'h101] = 8'h20;
    boot(0);
    cyc = 0; rets = 0;
    while (!halted && cyc < 60) begin
      tick();
      cyc++;
      if (retire) rets++;
    end
    // One BOOT cycle plus 4 + 4 + 3 instruction cycles.
    n_cmp++; if (cyc != 12) begin n_bad++; $display("FAIL la_cycles: got %0d want 12", cyc); end
    n_cmp++; if (rets != 3) begin n_bad++; $display("FAIL la_retires: got %0d want 3", rets); end
    n_cmp++; if (halted !== 1'b1) begin n_bad++; $display("FAIL la_halted: got %b want 1", halted); end
    n_cmp++; if (acc_out !== 8'h10) begin n_bad++; $display("FAIL la_acc: got %h want 10", acc_out); end
    n_cmp++; if (zero !== 1'b0) begin n_bad++; $display("FAIL la_zero: got %b want 0", zero); end
    n_cmp++; if (pc_out !== 13'h6) begin n_bad++; $display("FAIL la_pc: got %h want 6", pc_out); end
    n_cmp++; if (mem_req !== 1'b0) begin n_bad++; $display("FAIL la_req: got %b want 0", mem_req); end
  endtask

  task automatic test_sto_wait();
    int          cyc, guard, wr0;
    logic        p_req, p_rdy, p_we;
    logic [12:0] p_addr;
    logic [7:0]  p_wdata;
    clear_mem();
    mem[0] = 8'hA0; mem[1] = 8'h50;  // LDA 0x50
    mem[2] = 8'hDF; mem[3] = 8'hFF;  // STO 0x1FFF
    mem[4] = 8'h00; mem[5] = 8'h00;  // HLT
    mem[13'h50] = 8'hA5;
    boot(3);
    wr0 = wr_count;
    guard = 0;
    while (!retire && guard < 100) begin tick(); guard++; end
    n_cmp++; if (retire !== 1'b1) begin n_bad++; $display("FAIL sto_lda_timeout: got %b want 1", retire); end
    tick();
    cyc = 1; p_req = 1'b0; p_rdy = 1'b0; p_we = 1'b0; p_addr = '0; p_wdata = '0;
    while (cyc < 100) begin
      if (p_req && !p_rdy && mem_req) begin
        n_cmp++; if (mem_addr !== p_addr) begin n_bad++; $display("FAIL sto_addr_stable: got %h want %h", mem_addr, p_addr); end
        n_cmp++; if (mem_we !== p_we) begin n_bad++; $display("FAIL sto_we_stable: got %b want %b", mem_we, p_we); end
        if (p_we) begin
          n_cmp++; if (mem_wdata !== p_wdata) begin n_bad++; $display("FAIL sto_wdata_stable: got %h want %h", mem_wdata, p_wdata); end
        end
      end
      if (mem_req && mem_we) begin
        n_cmp++; if (mem_addr !== 13'h1FFF) begin n_bad++; $display("FAIL sto_waddr: got %h want 1fff", mem_addr); end
        n_cmp++; if (mem_wdata !== 8'hA5) begin n_bad++; $display("FAIL sto_wdata: got %h want a5", mem_wdata); end
      end
      if (retire) break;
      p_req = mem_req; p_rdy = mem_ready; p_we = mem_we; p_addr = mem_addr; p_wdata = mem_wdata;
      tick();
      cyc++;
    end
    // 4 base cycles plus 3 wait cycles on each of the three transactions.
    n_cmp++; if (cyc != 13) begin n_bad++; $display("FAIL sto_cycles: got %0d want 13", cyc); end
    tick();
    run_to_halt("sto", 60);
    n_cmp++; if (wr_count - wr0 != 1) begin n_bad++; $display("FAIL sto_writes: got %0d want 1", wr_count - wr0); end
    n_cmp++; if (last_wr_addr !== 13'h1FFF) begin n_bad++; $display("FAIL sto_log_addr: got %h want 1fff", last_wr_addr); end
    n_cmp++; if (last_wr_data !== 8'hA5) begin n_bad++; $display("FAIL sto_log_data: got %h want a5", last_wr_data); end
    n_cmp++; if (pc_out !== 13'h6) begin n_bad++; $display("FAIL sto_pc: got %h want 6", pc_out); end
  endtask

  task automatic test_skz_jmp();
    logic [12:0] fa[$];
    logic [12:0] pcs[$];
    logic [12:0] exp_fa[8];
    logic [12:0] exp_pc[4];
    logic        pr;
    exp_fa = '{13'h0, 13'h1, 13'h4, 13'h5, 13'h1FFE, 13'h1FFF, 13'h2, 13'h3};
    exp_pc = '{13'h4, 13'h1FFE, 13'h2, 13'h4};
    clear_mem();
    mem[0] = 8'h20; mem[1] = 8'h00;              // SKZ, taken with acc=0
    mem[2] = 8'h00; mem[3] = 8'h00;              // HLT
    mem[4] = 8'hFF; mem[5] = 8'hFE;              // JMP 0x1FFE
    mem[13'h1FFE] = 8'h20; mem[13'h1FFF] = 8'h00; // SKZ across the top of memory
    boot(0);
    pr = 1'b0;
    for (int c = 0; c < 80 && !halted; c++) begin
      tick();
      if (pr) pcs.push_back(pc_out);
      if (mem_req && mem_ready && !mem_we) fa.push_back(mem_addr);
      pr = retire;
    end
    n_cmp++; if (fa.size() != 8) begin n_bad++; $display("FAIL sj_nfetch: got %0d want 8", fa.size()); end
    for (int i = 0; i < 8; i++) begin
      if (i < fa.size()) begin
        n_cmp++; if (fa[i] !== exp_fa[i]) begin n_bad++; $display("FAIL sj_fetch%0d: got %h want %h", i, fa[i], exp_fa[i]); end
      end
    end
    n_cmp++; if (pcs.size() != 4) begin n_bad++; $display("FAIL sj_nret: got %0d want 4", pcs.size()); end
    for (int i = 0; i < 4; i++) begin
      if (i < pcs.size()) begin
        n_cmp++; if (pcs[i] !== exp_pc[i]) begin n_bad++; $display("FAIL sj_pc%0d: got %h want %h", i, pcs[i], exp_pc[i]); end
      end
    end
    n_cmp++; if (halted !== 1'b1) begin n_bad++; $display("FAIL sj_halted: got %b want 1", halted); end
  endtask

  task automatic test_halt_resume();
    clear_mem();
    mem[0] = 8'hA0; mem[1] = 8'h40;  // LDA 0x40
    mem[2] = 8'h00; mem[3] = 8'h00;  // HLT
    mem[4] = 8'h20; mem[5] = 8'h00;  // SKZ, not taken with acc=7
    mem[6] = 8'h00; mem[7] = 8'h00;  // HLT
    mem[13'h40] = 8'h07;
    boot(0);
    run_to_halt("hr1", 40);
    n_cmp++; if (pc_out !== 13'h4) begin n_bad++; $display("FAIL hr_pc1: got %h want 4", pc_out); end
    for (int i = 0; i < 5; i++) tick();
    n_cmp++; if (halted !== 1'b1) begin n_bad++; $display("FAIL hr_hold: got %b want 1", halted); end
    n_cmp++; if (mem_req !== 1'b0) begin n_bad++; $display("FAIL hr_req_idle: got %b want 0", mem_req); end
    resume = 1'b1;
    tick();
    resume = 1'b0;
    n_cmp++; if (halted !== 1'b0) begin n_bad++; $display("FAIL hr_resumed: got %b want 0", halted); end
    n_cmp++; if (mem_req !== 1'b1) begin n_bad++; $display("FAIL hr_req: got %b want 1", mem_req); end
    n_cmp++; if (mem_addr !== 13'h4) begin n_bad++; $display("FAIL hr_addr: got %h want 4", mem_addr); end
    // Pulse resume in every retire cycle: while running, and on the edge entering HALT.
    for (int c = 0; c < 50 && !halted; c++) begin
      resume = retire;
      tick();
    end
    resume = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    n_cmp++; if (halted !== 1'b1) begin n_bad++; $display("FAIL hr_halted2: got %b want 1", halted); end
    n_cmp++; if (pc_out !== 13'h8) begin n_bad++; $display("FAIL hr_pc2: got %h want 8", pc_out); end
    n_cmp++; if (acc_out !== 8'h07) begin n_bad++; $display("FAIL hr_acc: got %h want 07", acc_out); end
  endtask

  task automatic test_reset_mid();
    int guard, wr0;
    clear_mem();
    mem[0] = 8'hC0; mem[1] = 8'h30;  // STO 0x30
    mem[13'h30] = 8'h5A;
    boot(3);
    wr0 = wr_count;
    guard = 0;
    while (!(mem_req && mem_we) && guard < 40) begin tick(); guard++; end
    n_cmp++; if (mem_we !== 1'b1) begin n_bad++; $display("FAIL rm_no_write_phase: got %b want 1", mem_we); end
    tick();
    #2;
    rst = 1'b1;
    #1;
    n_cmp++; if (mem_req !== 1'b0) begin n_bad++; $display("FAIL rm_req_drop: got %b want 0", mem_req); end
    n_cmp++; if (mem_we !== 1'b0) begin n_bad++; $display("FAIL rm_we_drop: got %b want 0", mem_we); end
    tick();
    n_cmp++; if (wr_count != wr0) begin n_bad++; $display("FAIL rm_writes: got %0d want %0d", wr_count, wr0); end
    wait_cfg = 0;
    rst = 1'b0;
    n_cmp++; if (pc_out !== 13'h0) begin n_bad++; $display("FAIL rm_pc: got %h want 0", pc_out); end
    tick();
    n_cmp++; if (mem_req !== 1'b1) begin n_bad++; $display("FAIL rm_reboot_req: got %b want 1", mem_req); end
    n_cmp++; if (mem_addr !== 13'h0) begin n_bad++; $display("FAIL rm_reboot_addr: got %h want 0", mem_addr); end
  endtask

  task automatic test_param16();
    int c, rets;
    mem16[0] = 16'hA000; mem16[1] = 16'h0100;  // LDA 0x00100
    mem16[2] = 16'h81FA; mem16[3] = 16'hBCDE;  // XOR 0xABCDE, ignored hi bits set
    mem16[4] = 16'h0000; mem16[5] = 16'h0000;  // HLT
    mem16[20'h00100] = 16'h1234;
    mem16[20'hABCDE] = 16'hFFFF;
    rst16 = 1'b1;
    tick();
    rst16 = 1'b0;
    c = 0; rets = 0;
    while (!halted16 && c < 40) begin
      tick();
      c++;
      if (retire16) rets++;
    end
    n_cmp++; if (halted16 !== 1'b1) begin n_bad++; $display("FAIL p16_halted: got %b want 1", halted16); end
    n_cmp++; if (acc16 !== 16'hEDCB) begin n_bad++; $display("FAIL p16_acc: got %h want edcb", acc16); end
    n_cmp++; if (zero16 !== 1'b0) begin n_bad++; $display("FAIL p16_zero: got %b want 0", zero16); end
    n_cmp++; if (pc16 !== 20'h6) begin n_bad++; $display("FAIL p16_pc: got %h want 6", pc16); end
    n_cmp++; if (rets != 3) begin n_bad++; $display("FAIL p16_retires: got %0d want 3", rets); end
    n_cmp++; if (req16 !== 1'b0 || we16 !== 1'b0) begin n_bad++; $display("FAIL p16_idle: req=%b we=%b want 0 0", req16, we16); end
    n_cmp++; if (wdata16 !== 16'h0) begin n_bad++; $display("FAIL p16_wdata: got %h want 0", wdata16); end
  endtask

  initial begin
    rst      = 1'b1;
    rst16    = 1'b1;
    resume   = 1'b0;
    resume16 = 1'b0;
    test_reset();
    test_lda_add();
    test_sto_wait();
    test_skz_jmp();
    test_halt_resume();
    test_reset_mid();
    test_param16();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
